csr_axil_slave: RTL and testbench

AXI4-Lite responder holding the accelerator's control/status registers. It accepts single-beat CSR writes and reads from the host, exposes the nine configuration words and the command word to the compute core, and pulses a start strobe on command writes. It also tracks a sticky done flag and drives the interrupt.

---
 rtl/csr_axil_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_csr_axil_slave.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_axil_slave.sv
// AXI4-Lite control/status register block for the accelerator: command word,
// configuration words, sticky done flag with interrupt, and start strobe.
module csr_axil_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_CFG    = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
  input  logic [2:0]                    s_axi_awprot,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
  input  logic [2:0]                    s_axi_arprot,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [DATA_WIDTH-1:0]         s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [NUM_CFG*DATA_WIDTH-1:0] cfg_flat,
  output logic [DATA_WIDTH-1:0]         cmd,
  output logic                          cmd_valid,
  input  logic                          busy,
  input  logic                          done_pulse,
  output logic                          irq
);

  localparam int         STRB_W      = DATA_WIDTH / 8;
  localparam logic [3:0] IDX_CMD     = 4'd0;
  localparam logic [3:0] IDX_STATUS  = 4'(NUM_CFG + 1);
  localparam logic [3:0] IDX_IRQ_EN  = 4'(NUM_CFG + 2);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]     strb_v
  );
    logic [DATA_WIDTH-1:0] res_v;
    res_v = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb_v[b]) res_v[8*b +: 8] = new_v[8*b +: 8];
      else           res_v[8*b +: 8] = old_v[8*b +: 8];
    end
    return res_v;
  endfunction

  logic                          aw_held_r;
  logic [3:0]                    wa_idx_r;
  logic                          w_held_r;
  logic [DATA_WIDTH-1:0]         wdata_r;
  logic [STRB_W-1:0]             wstrb_r;
  logic                          bvalid_r;
  logic [1:0]                    bresp_r;
  logic                          rvalid_r;
  logic [DATA_WIDTH-1:0]         rdata_r;
  logic [1:0]                    rresp_r;
  logic [NUM_CFG*DATA_WIDTH-1:0] cfg_r;
  logic [DATA_WIDTH-1:0]         cmd_r;
  logic                          cmd_valid_r;
  logic                          done_r;
  logic                          irq_en_r;
  logic                          irq_r;

  logic                          aw_hs_s;
  logic                          w_hs_s;
  logic                          ar_hs_s;
  logic                          commit_s;
  logic                          wr_cfg_s;
  logic [1:0]                    wr_resp_s;
  logic                          cmd_fire_s;
  logic                          done_clr_s;
  logic [3:0]                    ra_idx_s;
  logic                          rd_cfg_hit_s;
  logic [DATA_WIDTH-1:0]         rd_cfg_s;
  logic [DATA_WIDTH-1:0]         rd_data_s;
  logic [1:0]                    rd_resp_s;
  logic                          unused_s;

  assign s_axi_awready = ~rst & ~aw_held_r & ~bvalid_r;
  assign s_axi_wready  = ~rst & ~w_held_r & ~bvalid_r;
  assign s_axi_arready = ~rst & ~rvalid_r;

  assign aw_hs_s  = s_axi_awvalid & s_axi_awready;
  assign w_hs_s   = s_axi_wvalid & s_axi_wready;
  assign ar_hs_s  = s_axi_arvalid & s_axi_arready;
  assign commit_s = aw_held_r & w_held_r;

  assign wr_cfg_s     = (wa_idx_r >= 4'd1) && (wa_idx_r <= 4'(NUM_CFG));
  assign done_clr_s   = commit_s & (wa_idx_r == IDX_STATUS) & wstrb_r[0] & wdata_r[1];
  assign ra_idx_s     = s_axi_araddr[5:2];
  assign rd_cfg_hit_s = (ra_idx_s >= 4'd1) && (ra_idx_s <= 4'(NUM_CFG));

  assign unused_s = ^{s_axi_awprot, s_axi_arprot,
                      s_axi_awaddr[ADDR_WIDTH-1:6], s_axi_awaddr[1:0],
                      s_axi_araddr[ADDR_WIDTH-1:6], s_axi_araddr[1:0]};

  // Write decode: response code and whether a command write launches the core.
  always_comb begin
    wr_resp_s  = RESP_OKAY;
    cmd_fire_s = 1'b0;
    case (wa_idx_r)
      IDX_CMD: begin
        if (busy) begin
          wr_resp_s = RESP_SLVERR;
        end else begin
          cmd_fire_s = (wstrb_r != {STRB_W{1'b0}});
        end
      end
      IDX_STATUS, IDX_IRQ_EN: wr_resp_s = RESP_OKAY;
      default: begin
        if (wr_cfg_s) wr_resp_s = RESP_OKAY;
        else          wr_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // Configuration word selected by the read address (zero when not a CFG slot).
  always_comb begin
    rd_cfg_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_CFG; i++) begin
      rd_cfg_s = rd_cfg_s |
                 ({DATA_WIDTH{ra_idx_s == 4'(i + 1)}} & cfg_r[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Read mux over the register map.
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    rd_resp_s = RESP_OKAY;
    case (ra_idx_s)
      IDX_CMD:    rd_data_s = cmd_r;
      IDX_STATUS: rd_data_s = {{(DATA_WIDTH-2){1'b0}}, done_r, busy};
      IDX_IRQ_EN: rd_data_s = {{(DATA_WIDTH-1){1'b0}}, irq_en_r};
      default: begin
        if (rd_cfg_hit_s) rd_data_s = rd_cfg_s;
        else              rd_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // AW/W holding registers and the B response channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_r <= 1'b0;
      wa_idx_r  <= 4'd0;
      w_held_r  <= 1'b0;
      wdata_r   <= {DATA_WIDTH{1'b0}};
      wstrb_r   <= {STRB_W{1'b0}};
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      if (aw_hs_s) begin
        aw_held_r <= 1'b1;
        wa_idx_r  <= s_axi_awaddr[5:2];
      end else if (commit_s) begin
        aw_held_r <= 1'b0;
      end
      if (w_hs_s) begin
        w_held_r <= 1'b1;
        wdata_r  <= s_axi_wdata;
        wstrb_r  <= s_axi_wstrb;
      end else if (commit_s) begin
        w_held_r <= 1'b0;
      end
      if (commit_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= wr_resp_s;
      end else if (s_axi_bready) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Register file updates, start strobe, sticky done and registered interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_r       <= {(NUM_CFG*DATA_WIDTH){1'b0}};
      cmd_r       <= {DATA_WIDTH{1'b0}};
      cmd_valid_r <= 1'b0;
      done_r      <= 1'b0;
      irq_en_r    <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      cmd_valid_r <= commit_s & cmd_fire_s;
      if (commit_s && cmd_fire_s) cmd_r <= merge_bytes(cmd_r, wdata_r, wstrb_r);
      for (int i = 0; i < NUM_CFG; i++) begin
        if (commit_s && (wa_idx_r == 4'(i + 1))) begin
          cfg_r[i*DATA_WIDTH +: DATA_WIDTH] <=
            merge_bytes(cfg_r[i*DATA_WIDTH +: DATA_WIDTH], wdata_r, wstrb_r);
        end
      end
      if (commit_s && (wa_idx_r == IDX_IRQ_EN) && wstrb_r[0]) irq_en_r <= wdata_r[0];
      // A completion landing on the same edge as a clear must not be lost.
      if (done_pulse)      done_r <= 1'b1;
      else if (done_clr_s) done_r <= 1'b0;
      irq_r <= done_r & irq_en_r;
    end
  end

  // R channel: capture on the AR handshake and hold until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= 1'b0;
      rdata_r  <= {DATA_WIDTH{1'b0}};
      rresp_r  <= RESP_OKAY;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_data_s;
      rresp_r  <= rd_resp_s;
    end else if (s_axi_rready) begin
      rvalid_r <= 1'b0;
    end
  end

  assign s_axi_bvalid = bvalid_r;
  assign s_axi_bresp  = bresp_r;
  assign s_axi_rvalid = rvalid_r;
  assign s_axi_rdata  = rdata_r;
  assign s_axi_rresp  = rresp_r;
  assign cfg_flat     = cfg_r;
  assign cmd          = cmd_r;
  assign cmd_valid    = cmd_valid_r;
  assign irq          = irq_r;

endmodule

// File: tb/tb_csr_axil_slave.sv
// Self-checking bench for csr_axil_slave: directed register-map scenarios plus
// randomized traffic scored against a register-level reference model.
module tb_csr_axil_slave;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NC = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   s_axi_awaddr;
  logic [2:0]      s_axi_awprot;
  logic            s_axi_awvalid;
  logic            s_axi_awready;
  logic [DW-1:0]   s_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic            s_axi_wvalid;
  logic            s_axi_wready;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready;
  logic [AW-1:0]   s_axi_araddr;
  logic [2:0]      s_axi_arprot;
  logic            s_axi_arvalid;
  logic            s_axi_arready;
  logic [DW-1:0]   s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rvalid;
  logic            s_axi_rready;
  logic [NC*DW-1:0] cfg_flat;
  logic [DW-1:0]   cmd;
  logic            cmd_valid;
  logic            busy;
  logic            done_pulse;
  logic            irq;

  always #5 clk = ~clk;

  csr_axil_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CFG(NC)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .cfg_flat(cfg_flat), .cmd(cmd), .cmd_valid(cmd_valid),
    .busy(busy), .done_pulse(done_pulse), .irq(irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the architectural registers only.
  logic [31:0] cfg_m [NC];
  logic [31:0] cmd_m;
  logic        done_m;
  logic        irq_en_m;

  task automatic chk(input string tag, input logic [NC*DW-1:0] obs, input logic [NC*DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) cfg_m[i] = 32'h0;
    cmd_m = 32'h0; done_m = 1'b0; irq_en_m = 1'b0;
  endtask

  function automatic logic [NC*DW-1:0] cfg_exp();
    logic [NC*DW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*DW +: DW] = cfg_m[i];
    return r;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                             input logic bsy, output logic [1:0] resp, output logic strobe);
    int idx;
    idx = int'(addr[5:2]);
    resp = 2'b00; strobe = 1'b0;
    if (idx == 0) begin
      if (bsy) resp = 2'b10;
      else if (s != 4'h0) begin cmd_m = apply_strb(cmd_m, d, s); strobe = 1'b1; end
    end else if (idx <= NC) begin
      cfg_m[idx-1] = apply_strb(cfg_m[idx-1], d, s);
    end else if (idx == NC + 1) begin
      if (s[0] && d[1]) done_m = 1'b0;
    end else if (idx == NC + 2) begin
      if (s[0]) irq_en_m = d[0];
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] resp);
    int idx;
    idx = int'(addr[5:2]);
    resp = 2'b00; d = 32'h0;
    if (idx == 0)            d = cmd_m;
    else if (idx <= NC)      d = cfg_m[idx-1];
    else if (idx == NC + 1)  d = 32'(2 * int'(done_m) + int'(busy));
    else if (idx == NC + 2)  d = {31'h0, irq_en_m};
    else                     resp = 2'b10;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int hold, input bit pulse_at_commit);
    logic [1:0] exp_resp;
    logic       exp_strobe;
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    s_axi_awaddr = addr; s_axi_wdata = d; s_axi_wstrb = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      s_axi_awvalid = !aw_done && (cyc >= aw_dly);
      s_axi_wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk($sformatf("wr_handshake@%0h", addr), {aw_done, w_done}, 2'b11);
    chk("b_not_early", s_axi_bvalid, 1'b0);
    model_write(addr, d, s, busy, exp_resp, exp_strobe);
    if (pulse_at_commit) done_pulse = 1'b1;
    @(posedge clk); #1;
    done_pulse = 1'b0;
    if (pulse_at_commit) done_m = 1'b1;
    chk("bvalid", s_axi_bvalid, 1'b1);
    chk($sformatf("bresp@%0h", addr), s_axi_bresp, exp_resp);
    chk($sformatf("cfg_flat@%0h", addr), cfg_flat, cfg_exp());
    chk("cmd", cmd, cmd_m);
    chk("cmd_valid_pulse", cmd_valid, exp_strobe);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("b_hold_bvalid", s_axi_bvalid, 1'b1);
      chk("b_hold_awready", s_axi_awready, 1'b0);
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    chk("bvalid_cleared", s_axi_bvalid, 1'b0);
    chk("cmd_valid_one_cycle", cmd_valid, 1'b0);
    chk("irq_after_write", irq, done_m & irq_en_m);
  endtask

  task automatic axi_read(input logic [31:0] addr);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    bit hs, took;
    int cyc;
    took = 0; cyc = 0;
    model_read(addr, exp_d, exp_r);
    s_axi_araddr = addr;
    while (!took && cyc < 50) begin
      s_axi_arvalid = 1'b1;
      hs = s_axi_arready;
      @(posedge clk); #1;
      cyc++;
      if (hs) took = 1;
    end
    s_axi_arvalid = 1'b0;
    chk($sformatf("rd_handshake@%0h", addr), took, 1'b1);
    chk("rvalid", s_axi_rvalid, 1'b1);
    chk($sformatf("rdata@%0h", addr), s_axi_rdata, exp_d);
    chk($sformatf("rresp@%0h", addr), s_axi_rresp, exp_r);
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    chk("rvalid_cleared", s_axi_rvalid, 1'b0);
    chk("arready_back", s_axi_arready, 1'b1);
  endtask

  logic [31:0] cfg_vals [NC];

  initial begin
    rst = 1'b1;
    s_axi_awaddr = 32'h0; s_axi_awprot = 3'b000; s_axi_awvalid = 1'b0;
    s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = 32'h0; s_axi_arprot = 3'b000; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    busy = 1'b0; done_pulse = 1'b0;
    model_reset();
    cfg_vals = '{32'h4400_0000, 32'h64, 32'h20, 32'h3, 32'h10, 32'h4401_0000, 32'd49, 32'd9, 32'h7};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", s_axi_awready, 1'b0);
    chk("rst_wready", s_axi_wready, 1'b0);
    chk("rst_arready", s_axi_arready, 1'b0);
    chk("rst_valids", {s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp}, 6'h0);
    chk("rst_rdata", s_axi_rdata, 32'h0);
    chk("rst_cfg", cfg_flat, '0);
    chk("rst_cmd", {cmd, cmd_valid, irq}, '0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    // AW first, W a cycle later, high address bits ignored
    axi_write(32'h4000_0004, 32'h4200_0000, 4'hF, 0, 1, 0, 0);
    chk("cfg0_direct", cfg_flat[31:0], 32'h4200_0000);
    axi_read(32'h4000_0004);

    // All CFG words, AW-before-W then simultaneous AW/W
    for (int i = 0; i < NC; i++) axi_write(32'(4 * (i + 1)), cfg_vals[i], 4'hF, 0, 2, 0, 0);
    for (int i = 0; i < NC; i++) axi_read(32'(4 * (i + 1)));
    for (int i = 0; i < NC; i++) axi_write(32'(4 * (i + 1)), ~cfg_vals[i], 4'hF, 0, 0, 0, 0);
    for (int i = 0; i < NC; i++) axi_read(32'(4 * (i + 1)));

    // Command strobe, then a command while busy
    axi_write(32'h0, 32'h0302_FFE1, 4'hF, 2, 0, 0, 0);
    chk("cmd_direct", cmd, 32'h0302_FFE1);
    busy = 1'b1;
    axi_write(32'h0, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
    chk("cmd_busy_unchanged", cmd, 32'h0302_FFE1);
    axi_read(32'h28);
    busy = 1'b0;

    // Byte-lane strobes, and an empty strobe
    axi_write(32'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0);
    axi_write(32'h4, 32'h1234_5678, 4'b0101, 1, 0, 0, 0);
    chk("strb_merge", cfg_flat[31:0], 32'hFF34_FF78);
    axi_write(32'h4, 32'h0, 4'h0, 0, 0, 0, 0);
    axi_write(32'h0, 32'h1111_1111, 4'h0, 0, 0, 0, 0);

    // Interrupt: enable, done pulse, clear racing a new pulse, then real clear
    axi_write(32'h2C, 32'h1, 4'hF, 0, 0, 0, 0);
    done_pulse = 1'b1;
    @(posedge clk); #1;
    done_pulse = 1'b0;
    done_m = 1'b1;
    chk("irq_not_yet", irq, 1'b0);
    @(posedge clk); #1;
    chk("irq_rises", irq, 1'b1);
    axi_read(32'h28);
    axi_write(32'h28, 32'h2, 4'hF, 0, 0, 0, 1);
    axi_read(32'h28);
    axi_write(32'h28, 32'h2, 4'hF, 0, 0, 0, 0);
    chk("irq_cleared", irq, 1'b0);
    axi_read(32'h2C);

    // Unmapped accesses and B back-pressure
    axi_read(32'h4000_0030);
    axi_write(32'h3C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0);
    axi_write(32'h8, 32'hCAFE_F00D, 4'hF, 0, 0, 5, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 4));
      a = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
      busy = 1'($urandom_range(0, 1));
      if (op <= 1) begin
        axi_read(a);
      end else if (op == 2) begin
        done_pulse = 1'b1;
        @(posedge clk); #1;
        done_pulse = 1'b0;
        done_m = 1'b1;
        @(posedge clk); #1;
        chk("rnd_irq", irq, irq_en_m);
      end else begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, 0);
      end
    end
    busy = 1'b0;

    // Reset between AW and W: nothing commits and everything clears
    s_axi_awaddr = 32'h4; s_axi_awvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    rst = 1'b1;
    s_axi_wdata = 32'hABCD_1234; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_mid_no_b", s_axi_bvalid, 1'b0);
    end
    chk("rst_mid_cfg", cfg_flat, '0);
    axi_read(32'h4);
    axi_read(32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
